// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv_unit_if
//  Purpose  : Issue/result bundle between the execute stage (master) and the
//             multi-cycle RV32M multiply/divide engine (slave).
//  Signals  : start    - issue request
//             funct3   - M-extension operation select
//             operand1 - rs1 value (dividend / multiplicand)
//             operand2 - rs2 value (divisor / multiplier)
//             flush    - abort the operation in flight
//             busy     - operation in flight, execute stage must stall
//             done     - one-cycle pulse, result valid
//             result   - final value, held until the next done
//  Revision : 1.0  initial release
// ============================================================================
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, operand1, operand2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, operand1, operand2, flush,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv_unit
//  Purpose  : Multi-cycle RV32M multiply/divide engine. Multiplies with an
//             unsigned shift-add on operand magnitudes (MUL_STEP bits/cycle),
//             divides with restoring division (1 bit/cycle), then applies the
//             sign fix-up in a single FIX cycle. Divide-by-zero, signed
//             overflow and multiply-by-zero finish straight from accept.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - ex_muldiv_unit_if.slave (start/funct3/operand1/operand2/
//                    flush in; busy/done/result out)
//  Revision : 1.0  initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    ex_muldiv_unit_if.slave bus
);

    localparam int c_K_MUL = XLEN / MUL_STEP;
    localparam int c_K_DIV = XLEN;
    localparam int c_CNT_W = $clog2(c_K_DIV + 1);

    localparam logic [c_CNT_W-1:0] c_K_MUL_LAST = c_CNT_W'(c_K_MUL - 1);
    localparam logic [c_CNT_W-1:0] c_K_DIV_LAST = c_CNT_W'(c_K_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [XLEN-1:0]    c_INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    // ------------------------------------------------------------------
    // State
    // r_acc holds {high, low}: for multiply the partial product shifts
    // down through it while the multiplier is consumed from the low half;
    // for divide the high half is the partial remainder and the low half
    // shifts the dividend out while the quotient shifts in.
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [2:0]          r_funct3;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opb;
    logic                r_neg_res;
    logic                r_neg_rem;
    logic [XLEN-1:0]     r_result;

    // ------------------------------------------------------------------
    // Accept-time decode (operates on the incoming request)
    // ------------------------------------------------------------------
    logic            w_is_div;
    logic            w_op1_signed;
    logic            w_op2_signed;
    logic            w_op1_neg;
    logic            w_op2_neg;
    logic [XLEN-1:0] w_op1_mag;
    logic [XLEN-1:0] w_op2_mag;
    logic            w_div_zero;
    logic            w_overflow;
    logic            w_mul_zero;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_val;
    logic            w_accept;

    assign w_is_div     = bus.funct3[2];
    // MUL's low word is sign-agnostic, so it is treated as unsigned.
    assign w_op1_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                          (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    assign w_op2_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                          (bus.funct3 == 3'b110);
    assign w_op1_neg    = w_op1_signed && bus.operand1[XLEN-1];
    assign w_op2_neg    = w_op2_signed && bus.operand2[XLEN-1];
    assign w_op1_mag    = w_op1_neg ? -bus.operand1 : bus.operand1;
    assign w_op2_mag    = w_op2_neg ? -bus.operand2 : bus.operand2;

    assign w_div_zero   = w_is_div && (bus.operand2 == '0);
    // Signed overflow only exists for DIV/REM (funct3[0] clear).
    assign w_overflow   = w_is_div && !bus.funct3[0] &&
                          (bus.operand1 == c_INT_MIN) && (bus.operand2 == '1);
    assign w_mul_zero   = !w_is_div &&
                          ((bus.operand1 == '0) || (bus.operand2 == '0));
    assign w_fast       = w_div_zero || w_overflow || w_mul_zero;

    always_comb begin
        w_fast_val = '0;
        if (w_div_zero) begin
            w_fast_val = bus.funct3[1] ? bus.operand1 : '1;
        end else if (w_overflow) begin
            w_fast_val = bus.funct3[1] ? '0 : bus.operand1;
        end
    end

    // Requests are only taken when nothing is in flight; a flush in the
    // same cycle drops the request.
    assign w_accept = bus.start && !bus.flush &&
                      ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));

    // ------------------------------------------------------------------
    // Multiply step: add multiplicand * low MUL_STEP multiplier bits into
    // the high half, then shift the whole accumulator down MUL_STEP bits.
    // The sum is MUL_STEP bits wider than XLEN so no carry is lost.
    // ------------------------------------------------------------------
    logic [XLEN+MUL_STEP-1:0] w_pp;
    logic [XLEN+MUL_STEP-1:0] w_mul_sum;
    logic [2*XLEN-1:0]        w_mul_next;

    always_comb begin
        w_pp = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (r_acc[i]) begin
                w_pp = w_pp + ({{MUL_STEP{1'b0}}, r_opb} << i);
            end
        end
    end

    assign w_mul_sum  = {{MUL_STEP{1'b0}}, r_acc[2*XLEN-1:XLEN]} + w_pp;
    assign w_mul_next = (2*XLEN)'({w_mul_sum, r_acc[XLEN-1:0]} >> MUL_STEP);

    // ------------------------------------------------------------------
    // Divide step (restoring): shift the next dividend bit into the
    // partial remainder and subtract the divisor; a borrow means restore.
    // ------------------------------------------------------------------
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_trial;
    logic [2*XLEN-1:0] w_div_next;

    assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_opb};
    assign w_div_next  = w_div_trial[XLEN]
                       ? {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                       : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    logic w_last;
    assign w_last = r_funct3[2] ? (r_cnt == c_K_DIV_LAST)
                                : (r_cnt == c_K_MUL_LAST);

    // ------------------------------------------------------------------
    // Sign fix-up and result selection
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_val;

    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quo  = r_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_val = '0;
        case (r_funct3)
            3'b000:                 w_fix_val = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_val = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_val = w_quo;
            default:                w_fix_val = w_rem;
        endcase
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_funct3  <= '0;
            r_acc     <= '0;
            r_opb     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (w_accept) begin
                        r_funct3  <= bus.funct3;
                        r_cnt     <= '0;
                        r_neg_res <= w_op1_neg ^ w_op2_neg;
                        r_neg_rem <= w_op1_neg;
                        if (w_is_div) begin
                            r_acc <= {{XLEN{1'b0}}, w_op1_mag};
                            r_opb <= w_op2_mag;
                        end else begin
                            r_acc <= {{XLEN{1'b0}}, w_op2_mag};
                            r_opb <= w_op1_mag;
                        end
                        if (w_fast) begin
                            r_result <= w_fast_val;
                            r_state  <= c_ST_DONE;
                        end else begin
                            r_state  <= c_ST_CALC;
                        end
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_CALC: begin
                    if (bus.flush) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_acc <= r_funct3[2] ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + c_CNT_ONE;
                        if (w_last) begin
                            r_state <= c_ST_FIX;
                        end
                    end
                end
                c_ST_FIX: begin
                    if (bus.flush) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_result <= w_fix_val;
                        r_state  <= c_ST_DONE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Outputs decode straight from registers only.
    assign bus.busy   = (r_state == c_ST_CALC) || (r_state == c_ST_FIX);
    assign bus.done   = (r_state == c_ST_DONE);
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle RV32M multiply/divide engine beside the combinational execute stage.
- Execute stage issues an M-extension op (opcode OP, funct7=0000001) with start, stalls the pipeline while busy, and writes result back on done.
- Parametrised in data width and multiplier bits-per-cycle; supports mid-operation flush from the core controller for jumps and traps.

Parameters:
XLEN, 32, operand/result width (even, >=8)
MUL_STEP, 4, multiplier bits retired per cycle; must divide XLEN; MUL iteration count K_MUL=XLEN/MUL_STEP
(divider fixed at 1 quotient bit per cycle, K_DIV=XLEN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  issue request; sampled only in IDLE or DONE
funct3  in  3  RV M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand1  in  XLEN  rs1 value (dividend / multiplicand)
operand2  in  XLEN  rs2 value (divisor / multiplier)
flush  in  1  abort current op
busy  out  1  op in flight (CALC or FIX)
done  out  1  one-cycle pulse, result valid
result  out  XLEN  final value; holds until next done

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, all internal registers 0. rst has priority over flush and start.
- States: IDLE, CALC, FIX, DONE.
  - busy=1 only in CALC and FIX.
  - done=1 only in DONE.
  - DONE returns to IDLE unless start is high, in which case back-to-back issue proceeds as from IDLE.
- Accept: start=1 in IDLE/DONE at cycle t latches funct3, operand magnitudes, sign flags and counter.
  - Signedness: MULH takes both operands signed; MULHSU takes op1 signed, op2 unsigned; DIV/REM take both signed; MULHU, DIVU and REMU are unsigned.
  - MUL's low word is sign-agnostic.
- Start in CALC/FIX is ignored; no queueing.
- CALC, multiply: unsigned shift-add on magnitudes, MUL_STEP bits/cycle, for K_MUL cycles into a 2*XLEN accumulator.
- CALC, divide: restoring division on magnitudes, one bit/cycle, for K_DIV cycles.
- FIX (1 cycle):
  - Multiply: negate the 2*XLEN product if the signs differ.
  - Divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Register result: MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
- Latency: done in cycle t+K+2. Defaults: MUL-class t+10, DIV-class t+34.
- Fast paths (decided at accept, go straight to DONE, done at t+1):
  - divide by zero: DIV/DIVU give all ones; REM/REMU give operand1.
  - signed overflow (DIV/REM, op1=1 followed by XLEN-1 zeros, op2=all ones): DIV gives op1; REM gives 0.
  - MUL-class with either operand zero gives 0.
- Flush:
  - In CALC/FIX: the next state is IDLE, no done is produced, result is unchanged, and busy=0 next cycle.
  - Flush in the same cycle as start in IDLE: start is dropped.
  - Flush in DONE: done still completes its single cycle.
- Counter wrap: the iteration counter is sized ceil(log2(K+1)) bits and never wraps. CALC exits exactly when it reaches K.
- Outputs are registered, with no combinational path from inputs to busy/done/result.

Test Plan:
- MUL 7 x 0xFFFFFFFD, start t=0 -> busy t=1..9, done t=10 only, result 0xFFFFFFEB. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> done t=34, 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> done t=1, 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> done t=1, 0x80000000. REM same operands -> 0.
- DIV issued t=0, flush t=5 -> busy=0 from t=6, no done ever, result keeps prior value; new MUL 3x4 at t=6 -> done t=16, result 12.
- Start pulsed again at t=3 during MUL (different operands) -> ignored, first result delivered t=10. Start asserted in DONE cycle t=10 -> second op done t=20, no idle gap.
- rst asserted t=4 mid-DIV -> t=5 busy=0, done=0, result=0. Re-param sweep XLEN=16, MUL_STEP=2: MUL 0x00FF x 0x0101 -> done t=10, 0xFFFF.
